// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bundle between fetch_ctrl and imem.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // Fetch sequencer side: issues requests, receives the acknowledge and data.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    // Memory side: observes requests, returns the acknowledge and data.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer. Owns the architectural PC, runs the imem
// request/acknowledge handshake, presents fetched words to decode and applies
// branch redirects and decode stalls.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_ctrl_if.master imem,
    input  logic         br_taken,
    input  logic [31:0]  br_target,
    input  logic         stall,
    output logic         if_valid,
    output logic [31:0]  if_inst,
    output logic [31:0]  if_pc,
    output logic [31:0]  pc
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        FLUSH
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_redirect;
    logic [31:0] r_inst;
    logic [31:0] r_if_pc;
    logic        r_req;
    logic        r_valid;

    logic [31:0] w_pc_seq;
    logic [31:0] w_flush_target;

    // Sequential successor address; 32-bit wrap is intentional.
    assign w_pc_seq       = r_pc + PC_STEP;
    // A redirect arriving together with the flush ack supersedes the latched one.
    assign w_flush_target = br_taken ? br_target : r_redirect;

    // Fetch state machine: state, PC, redirect latch and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_redirect <= '0;
            r_inst     <= '0;
            r_if_pc    <= '0;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // One bubble after reset; acks seen here are ignored.
                    r_state <= FETCH;
                    r_req   <= 1'b1;
                end
                FETCH: begin
                    if (imem.imem_ack) begin
                        if (br_taken) begin
                            // Wrong-path word dropped; fetch the target next.
                            r_pc <= br_target;
                        end else begin
                            r_inst  <= imem.imem_rdata;
                            r_if_pc <= r_pc;
                            r_valid <= 1'b1;
                            r_pc    <= w_pc_seq;
                            r_req   <= 1'b0;
                            r_state <= ISSUE;
                        end
                    end else if (br_taken) begin
                        // Request cannot be withdrawn: park the target until the ack.
                        r_redirect <= br_target;
                        r_state    <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (imem.imem_ack) begin
                        r_pc    <= w_flush_target;
                        r_state <= FETCH;
                    end else if (br_taken) begin
                        r_redirect <= br_target;
                    end
                end
                ISSUE: begin
                    if (br_taken) begin
                        r_valid <= 1'b0;
                        r_pc    <= br_target;
                        r_req   <= 1'b1;
                        r_state <= FETCH;
                    end else if (!stall) begin
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_pc;
    assign if_valid       = r_valid;
    assign if_inst        = r_inst;
    assign if_pc          = r_if_pc;
    assign pc             = r_pc;

    // Address must stay frozen while a request waits for its ack.
    a_addr_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (r_req && !imem.imem_ack) |=> $stable(r_pc)
    );

    // A redirect cycle never produces a new instruction.
    a_no_issue_on_branch: assert property (
        @(posedge clk) disable iff (!rst_n)
        br_taken |=> !$rose(r_valid)
    );

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the architectural PC register.
- Drives the instruction-memory request/acknowledge handshake and presents fetched instructions to decode.
- Applies branch redirects, using the target already computed by the next-PC adder as pc+imm, and honours pipeline stalls.
- Sits between imem and the IF/ID boundary. It is the only writer of the PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  32  fetch address; equals pc and is stable while imem_req=1.
- imem_ack  in  1  single-cycle acknowledge; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- br_taken  in  1  redirect request from execute, one cycle wide.
- br_target  in  32  redirect target (pc+imm), valid while br_taken=1.
- stall  in  1  decode cannot accept this cycle.
- if_valid  out  1  if_inst/if_pc hold a live instruction.
- if_inst  out  32  registered instruction word.
- if_pc  out  32  registered address of if_inst.
- pc  out  32  current fetch PC.

Behaviour:
- Reset (rst_n=0, any state, including mid-handshake):
  - state=IDLE, pc=RESET_PC.
  - imem_req=0, if_valid=0, if_inst=0, if_pc=0.
  - Any ack still outstanding at reset is the memory's responsibility. The block ignores all acks in IDLE.
- States: IDLE, FETCH, ISSUE, FLUSH. imem_req=1 exactly in FETCH and FLUSH.
- IDLE: unconditionally moves to FETCH on the next edge. This gives one bubble after reset release.
- FETCH, ack=1 and br_taken=0:
  - if_inst<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+PC_STEP.
  - Go to ISSUE.
- FETCH, ack=1 and br_taken=1:
  - Discard imem_rdata as wrong-path. pc<=br_target, if_valid stays 0.
  - Remain in FETCH, issuing the target next cycle.
- FETCH, ack=0 and br_taken=1:
  - The request cannot be withdrawn. Latch br_target into a redirect register and go to FLUSH.
  - pc and imem_addr remain unchanged until the ack.
- FETCH, ack=0 and br_taken=0: hold; req and addr stay stable.
- FLUSH, on ack: discard data, pc<=redirect register, go to FETCH.
- FLUSH, br_taken=1: overwrites the redirect register; latest wins. This also applies in the same cycle as the ack, where br_target is used directly.
- ISSUE:
  - if_valid=1; if_inst and if_pc are held.
  - br_taken=1: if_valid<=0, pc<=br_target, go to FETCH. br_taken has priority over stall.
  - stall=0: the instruction is consumed this cycle. if_valid<=0, go to FETCH.
  - stall=1: remain in ISSUE; all outputs held.
- Throughput is at most one instruction per 2 cycles plus memory latency. Minimum latency is FETCH entry to if_valid = 1 cycle with a zero-wait ack.
- Arithmetic is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- br_target is not checked for alignment; misaligned values propagate to imem_addr.
- if_valid never rises on a cycle in which br_taken=1.
- Handshake invariant: imem_addr does not change while imem_req=1 and ack=0.

Test Plan:
- Reset then sequential run: RESET_PC=0, zero-wait ack with rdata=addr^32'hA5A5_0000.
  - if_pc sequence must be 0, 4, 8, 12.
  - if_valid pulses 1-of-2 cycles.
  - if_inst must be 32'hA5A5_0000, 32'hA5A5_0004, etc.
- Wait states: ack delayed 3 cycles at addr 8.
  - imem_req stays high with imem_addr=8 for 4 cycles.
  - Exactly one if_valid with if_pc=8.
- Stall hold: stall=1 for 5 cycles while if_pc=4.
  - if_valid, if_inst and if_pc are held constant, and imem_req=0 throughout.
  - After release, the next fetch is at addr 8.
- Redirect with outstanding request: in FETCH at addr 12 with ack pending, pulse br_taken with br_target=32'h100. Then ack after 2 cycles.
  - The returned word is dropped and no if_valid is produced.
  - The next imem_addr is 32'h100.
- Redirect priority and collisions:
  - br_taken=1 with target 32'h40 in ISSUE while stall=1: if_valid must drop next cycle and imem_addr must become 32'h40.
  - br_taken coincident with ack in FETCH: no if_valid, and the next address is br_target.
- Async reset mid-FLUSH: assert rst_n=0 between clock edges.
  - imem_req=0 and if_valid=0 must take effect immediately.
  - pc=RESET_PC, and the first fetch after release is at RESET_PC.
